// File: rtl/wb_machine_timer_pkg.sv
// Shared definitions for the Wishbone RISC-V machine timer: register
// offsets (word index taken from adr_i[4:2]), CTRL bit positions, reset
// constants and the byte-lane merge helper used by every writable register.
package wb_machine_timer_pkg;

    // Word offsets inside the 32-byte window.
    localparam logic [2:0] TIMER_MTIME_LO    = 3'd0;
    localparam logic [2:0] TIMER_MTIME_HI    = 3'd1;
    localparam logic [2:0] TIMER_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TIMER_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TIMER_CTRL        = 3'd4;

    // CTRL register layout.
    localparam int CTRL_EN_BIT = 0;

    // mtimecmp comes out of reset at its maximum so no interrupt fires
    // before software programs a deadline.
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // Kind of access decoded at a request edge.
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_ERR   = 2'd3
    } timer_acc_e;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wr_val,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = wr_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_machine_timer_prescaler.sv
// Prescaler for the machine timer: counts 0..PRESCALE-1 while enabled and
// raises tick (combinationally) in the cycle the count sits at its last
// value, so mtime increments on that same edge. The count holds while
// disabled. PRESCALE must be in 1..65535; PRESCALE=1 ticks every enabled cycle.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LP_LAST = 16'(PRESCALE - 32'd1);

    logic [15:0] r_count;
    logic        w_last;

    assign w_last = (r_count == LP_LAST);
    assign tick   = en & w_last;

    // Advance the divider while enabled, wrapping to zero on the tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 16'd0;
        end else if (en) begin
            if (w_last) begin
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/wb_machine_timer.sv
// Wishbone B4 classic slave implementing the RISC-V machine timer
// (64-bit mtime / mtimecmp, CTRL.en) and the level timer_interrupt.
// Every access takes two cycles: the request edge performs the read
// capture or the write, the following cycle shows ack_o/err_o, and the
// edge after that clears them regardless of stb_i.
// Optional build macro TIMER_SNAPSHOT_EN: a read of MTIME_LO latches
// mtime[63:32], and MTIME_HI then returns that latched half so a LO-then-HI
// read pair is coherent. Without the macro MTIME_HI reads the live value.
module wb_machine_timer
    import wb_machine_timer_pkg::*;
#(
    parameter int unsigned PRESCALE   = 1,
    parameter logic        CTRL_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic        timer_interrupt
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        r_irq;
`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] r_snap;
`endif

    logic [2:0]  w_idx;
    logic        w_req;
    logic        w_mapped;
    timer_acc_e  w_acc;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_ctrl;
    logic        w_en_clear;
    logic        w_en_eff;
    logic        w_tick;
    logic [31:0] w_rdata;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_cmp_nxt;
    logic        w_unused_adr;

    // Only adr_i[4:2] selects a register; the interconnect decodes the rest.
    assign w_unused_adr = &{1'b0, adr_i[31:5], adr_i[1:0]};

    assign w_idx    = adr_i[4:2];
    assign w_req    = stb_i & cyc_i & ~r_ack & ~r_err;
    assign w_mapped = (w_idx <= TIMER_CTRL);

    // Classify the access presented at this edge.
    always_comb begin
        w_acc = ACC_NONE;
        if (!w_req) begin
            w_acc = ACC_NONE;
        end else if (!w_mapped) begin
            w_acc = ACC_ERR;
        end else if (we_i) begin
            w_acc = ACC_WRITE;
        end else begin
            w_acc = ACC_READ;
        end
    end

    assign w_wr_mtime_lo = (w_acc == ACC_WRITE) & (w_idx == TIMER_MTIME_LO);
    assign w_wr_mtime_hi = (w_acc == ACC_WRITE) & (w_idx == TIMER_MTIME_HI);
    assign w_wr_cmp_lo   = (w_acc == ACC_WRITE) & (w_idx == TIMER_MTIMECMP_LO);
    assign w_wr_cmp_hi   = (w_acc == ACC_WRITE) & (w_idx == TIMER_MTIMECMP_HI);
    assign w_wr_ctrl     = (w_acc == ACC_WRITE) & (w_idx == TIMER_CTRL);

    // A write clearing en suppresses the tick on its own edge; setting en
    // only starts counting from the next edge.
    assign w_en_clear = w_wr_ctrl & sel_i[0] & ~dat_i[CTRL_EN_BIT];
    assign w_en_eff   = r_en & ~w_en_clear;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (w_en_eff),
        .tick  (w_tick)
    );

    // Read mux: register values as they stand before this edge's update.
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            TIMER_MTIME_LO:    w_rdata = r_mtime[31:0];
`ifdef TIMER_SNAPSHOT_EN
            TIMER_MTIME_HI:    w_rdata = r_snap;
`else
            TIMER_MTIME_HI:    w_rdata = r_mtime[63:32];
`endif
            TIMER_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            TIMER_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            TIMER_CTRL:        w_rdata[CTRL_EN_BIT] = r_en;
            default:           w_rdata = 32'd0;
        endcase
    end

    // Next mtime: a software write to either half wins over the tick.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_wr_mtime_lo) begin
            w_mtime_nxt[31:0] = merge_bytes(r_mtime[31:0], dat_i, sel_i);
        end else if (w_wr_mtime_hi) begin
            w_mtime_nxt[63:32] = merge_bytes(r_mtime[63:32], dat_i, sel_i);
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end else begin
            w_mtime_nxt = r_mtime;
        end
    end

    // Next mtimecmp from byte-lane writes to either half.
    always_comb begin
        w_cmp_nxt = r_mtimecmp;
        if (w_wr_cmp_lo) begin
            w_cmp_nxt[31:0] = merge_bytes(r_mtimecmp[31:0], dat_i, sel_i);
        end else if (w_wr_cmp_hi) begin
            w_cmp_nxt[63:32] = merge_bytes(r_mtimecmp[63:32], dat_i, sel_i);
        end else begin
            w_cmp_nxt = r_mtimecmp;
        end
    end

    // Timer state registers: mtime, mtimecmp and CTRL.en.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_en       <= CTRL_RESET;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            if (w_wr_ctrl && sel_i[0]) begin
                r_en <= dat_i[CTRL_EN_BIT];
            end else begin
                r_en <= r_en;
            end
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    // Latch the upper half whenever the lower half is read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snap <= 32'd0;
        end else if ((w_acc == ACC_READ) && (w_idx == TIMER_MTIME_LO)) begin
            r_snap <= r_mtime[63:32];
        end else begin
            r_snap <= r_snap;
        end
    end
`endif

    // Bus termination: one-cycle ack/err with read data, zero otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            case (w_acc)
                ACC_READ: begin
                    r_ack <= 1'b1;
                    r_err <= 1'b0;
                    r_dat <= w_rdata;
                end
                ACC_WRITE: begin
                    r_ack <= 1'b1;
                    r_err <= 1'b0;
                    r_dat <= 32'd0;
                end
                ACC_ERR: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b1;
                    r_dat <= 32'd0;
                end
                default: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    r_dat <= 32'd0;
                end
            endcase
        end
    end

    // Level interrupt from the current register values (one edge behind).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign ack_o           = r_ack;
    assign err_o           = r_err;
    assign dat_o           = r_dat;
    assign rty_o           = 1'b0;
    assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_wb_machine_timer.sv
// Directed testbench for wb_machine_timer. Two instances share the bus
// inputs: u_dut4 (PRESCALE=4) and u_dut1 (PRESCALE=1), both CTRL_RESET=1.
// Control/interrupt outputs are observed through a selectable mux; read
// data is captured from both instances on every access.
module tb_wb_machine_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;

    logic [31:0] dat4, dat1;
    logic        ack4, ack1, err4, err1, rty4, rty1, irq4, irq1;

    logic        use1;
    logic        s_ack, s_err, s_irq;
    logic [31:0] s_dat;

    int n_checks = 0;
    int n_fail   = 0;

    // Values captured by bus_xfer: at the termination cycle and one cycle later.
    logic [31:0] c_dat4, c_dat1, c_dat, p_dat;
    logic        c_ack, c_err, c_irq, p_ack, p_err, p_irq;

    localparam logic [31:0] BASE = 32'h4000_0000;

    always #5 clk = ~clk;

    assign s_ack = use1 ? ack1 : ack4;
    assign s_err = use1 ? err1 : err4;
    assign s_irq = use1 ? irq1 : irq4;
    assign s_dat = use1 ? dat1 : dat4;

    wb_machine_timer #(.PRESCALE(4), .CTRL_RESET(1'b1)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat4),
        .sel_i(sel), .we_i(we), .stb_i(stb), .cyc_i(cyc), .ack_o(ack4),
        .err_o(err4), .rty_o(rty4), .timer_interrupt(irq4)
    );

    wb_machine_timer #(.PRESCALE(1), .CTRL_RESET(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .adr_i(adr), .dat_i(wdat), .dat_o(dat1),
        .sel_i(sel), .we_i(we), .stb_i(stb), .cyc_i(cyc), .ack_o(ack1),
        .err_o(err1), .rty_o(rty1), .timer_interrupt(irq1)
    );

    // One two-cycle access; starts and ends 1 time unit after a rising edge.
    task automatic bus_xfer(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        we = w; adr = a; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        c_dat4 = dat4; c_dat1 = dat1; c_dat = s_dat;
        c_ack = s_ack; c_err = s_err; c_irq = s_irq;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        p_dat = s_dat; p_ack = s_ack; p_err = s_err; p_irq = s_irq;
    endtask

    task automatic do_reset();
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        adr = 32'd0; wdat = 32'd0; sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        use1 = 1'b0;
        do_reset();
        n_checks++;
        if ({ack4, err4, rty4, irq4, ack1, err1, rty1, irq1} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 00000000", {ack4, err4, rty4, irq4, ack1, err1, rty1, irq1});
        end
        n_checks++;
        if ({dat4, dat1} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_dat: got %h %h want 0 0", dat4, dat1);
        end
        bus_xfer(1'b0, BASE + 32'h0C, 32'd0, 4'hF);
        n_checks++;
        if (c_ack !== 1'b1 || c_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cmphi_ack: got ack=%b err=%b want ack=1 err=0", c_ack, c_err);
        end
        n_checks++;
        if (c_dat !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rst_cmphi_dat: got %h want ffffffff", c_dat);
        end
        n_checks++;
        if (c_irq !== 1'b0 || p_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq: got %b%b want 00", c_irq, p_irq);
        end
        n_checks++;
        if (p_ack !== 1'b0 || p_dat !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_term_clear: got ack=%b dat=%h want ack=0 dat=0", p_ack, p_dat);
        end
        // adr_i[1:0] ignored: CTRL read with low bits set.
        bus_xfer(1'b0, BASE + 32'h13, 32'd0, 4'hF);
        n_checks++;
        if (c_dat !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_ctrl: got %h want 00000001", c_dat);
        end
    endtask

    task automatic test_count();
        use1 = 1'b0;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        // Request edge is the 41st after reset: 40 prior edges.
        bus_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF);
        n_checks++;
        if (c_dat4 !== 32'(40 / 4)) begin
            n_fail++;
            $display("FAIL count_p4: got %0d want %0d", c_dat4, 40 / 4);
        end
        n_checks++;
        if (c_dat1 !== 32'd40) begin
            n_fail++;
            $display("FAIL count_p1: got %0d want 40", c_dat1);
        end
        repeat (5) @(posedge clk);
        #1;
        // 47 edges precede this request.
        bus_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF);
        n_checks++;
        if (c_dat4 !== 32'(47 / 4) || c_dat1 !== 32'd47) begin
            n_fail++;
            $display("FAIL count_again: got %0d/%0d want %0d/47", c_dat4, c_dat1, 47 / 4);
        end
    endtask

    task automatic test_carry();
        logic [31:0] exp_hi_first;
        use1 = 1'b1;
        bus_xfer(1'b1, BASE + 32'h10, 32'd0, 4'h1);
        bus_xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        bus_xfer(1'b1, BASE + 32'h04, 32'd0, 4'hF);
        bus_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL carry_lo_pre: got %h want ffffffff", c_dat1);
        end
        // Enable for exactly one tick (the ack-cycle edge), then clear en.
        bus_xfer(1'b1, BASE + 32'h10, 32'd1, 4'h1);
        bus_xfer(1'b1, BASE + 32'h10, 32'd0, 4'h1);
`ifdef TIMER_SNAPSHOT_EN
        exp_hi_first = 32'd0;
`else
        exp_hi_first = 32'd1;
`endif
        bus_xfer(1'b0, BASE + 32'h04, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== exp_hi_first) begin
            n_fail++;
            $display("FAIL carry_hi_first: got %h want %h", c_dat1, exp_hi_first);
        end
        bus_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'd0) begin
            n_fail++;
            $display("FAIL carry_lo: got %h want 00000000", c_dat1);
        end
        bus_xfer(1'b0, BASE + 32'h04, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'd1) begin
            n_fail++;
            $display("FAIL carry_hi: got %h want 00000001", c_dat1);
        end
    endtask

    task automatic test_irq();
        use1 = 1'b1;
        bus_xfer(1'b1, BASE + 32'h04, 32'd0, 4'hF);
        bus_xfer(1'b1, BASE + 32'h00, 32'd100, 4'hF);
        bus_xfer(1'b1, BASE + 32'h0C, 32'd0, 4'hF);
        n_checks++;
        if (p_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_cmphi: got %b want 0", p_irq);
        end
        bus_xfer(1'b1, BASE + 32'h08, 32'd100, 4'hF);
        n_checks++;
        if (c_irq !== 1'b0 || p_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rise: got ack-cycle=%b next=%b want 0 1", c_irq, p_irq);
        end
        bus_xfer(1'b1, BASE + 32'h08, 32'd200, 4'hF);
        n_checks++;
        if (c_irq !== 1'b1 || p_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: got ack-cycle=%b next=%b want 1 0", c_irq, p_irq);
        end
    endtask

    task automatic test_byte_lanes();
        use1 = 1'b1;
        bus_xfer(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'hF);
        bus_xfer(1'b1, BASE + 32'h08, 32'h1122_3344, 4'b0010);
        bus_xfer(1'b0, BASE + 32'h08, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'hFFFF_33FF) begin
            n_fail++;
            $display("FAIL lanes_0010: got %h want ffff33ff", c_dat1);
        end
        bus_xfer(1'b1, BASE + 32'h08, 32'h0000_0000, 4'b0000);
        n_checks++;
        if (c_ack !== 1'b1 || c_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes_sel0_ack: got ack=%b err=%b want 1 0", c_ack, c_err);
        end
        bus_xfer(1'b0, BASE + 32'h08, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'hFFFF_33FF) begin
            n_fail++;
            $display("FAIL lanes_sel0_keep: got %h want ffff33ff", c_dat1);
        end
    endtask

    task automatic test_reserved();
        use1 = 1'b1;
        we = 1'b1; adr = BASE + 32'h18; wdat = 32'd0; sel = 4'hF;
        stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (s_err !== ((i % 2) == 0) || s_ack !== 1'b0 || s_dat !== 32'd0) begin
                n_fail++;
                $display("FAIL rsv_held[%0d]: got err=%b ack=%b dat=%h want err=%b ack=0 dat=0",
                         i, s_err, s_ack, s_dat, ((i % 2) == 0));
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        bus_xfer(1'b0, BASE + 32'h1C, 32'd0, 4'hF);
        n_checks++;
        if (c_err !== 1'b1 || c_ack !== 1'b0 || c_dat !== 32'd0 || p_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_read: got err=%b ack=%b dat=%h next_err=%b want 1 0 0 0",
                     c_err, c_ack, c_dat, p_err);
        end
        bus_xfer(1'b0, BASE + 32'h08, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'hFFFF_33FF) begin
            n_fail++;
            $display("FAIL rsv_cmplo_keep: got %h want ffff33ff", c_dat1);
        end
        bus_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF);
        n_checks++;
        if (c_dat1 !== 32'd100) begin
            n_fail++;
            $display("FAIL rsv_mtime_keep: got %0d want 100", c_dat1);
        end
    endtask

    task automatic test_back_to_back();
        use1 = 1'b1;
        bus_xfer(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        we = 1'b0; adr = BASE + 32'h10; wdat = 32'd0; sel = 4'hF;
        stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (s_ack !== ((i % 2) == 0) || s_err !== 1'b0 ||
                s_dat !== (((i % 2) == 0) ? 32'd1 : 32'd0)) begin
                n_fail++;
                $display("FAIL b2b_ctrl[%0d]: got ack=%b err=%b dat=%h want ack=%b err=0",
                         i, s_ack, s_err, s_dat, ((i % 2) == 0));
            end
        end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        use1 = 1'b0;
        test_reset();
        test_count();
        test_carry();
        test_irq();
        test_byte_lanes();
        test_reserved();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
